// File: rtl/cpu_pkg.sv
// Shared types and constants for the micro_riscv core and its memory-side glue.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_bridge.sv
// Bridges the core data port (stall-based) to a valid/ready data-memory bus,
// with alignment checking and a watchdog on unresponsive accesses.
//
// state | meaning
// IDLE  | no access in flight; aligned request accepted, misaligned one faulted
// REQ   | bus request presented, waiting for mem_req_ready_i
// WAIT  | request accepted, waiting for mem_rsp_valid_i
// DONE  | one-cycle result to the core, stall released
module dmem_bridge
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        cpu_re_i,
    input  logic        cpu_we_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    output logic        cpu_err_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_req_we_o,
    output logic [31:0] mem_req_addr_o,
    output logic [31:0] mem_req_wdata_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_rdata_i,
    input  logic        mem_rsp_err_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t      state_q, state_d;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic             we_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, rsp_take, tmo, last_cycle;

    // cnt_q counts REQ/WAIT cycles already spent, so the final permitted one sees CNT_LAST
    assign last_cycle      = (cnt_q == CNT_LAST);
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;

    always_comb begin
        state_d         = state_q;
        cpu_stall_o     = 1'b0;
        cpu_err_o       = 1'b0;
        cpu_rdata_o     = '0;
        mem_req_valid_o = 1'b0;
        accept          = 1'b0;
        rsp_take        = 1'b0;
        tmo             = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_re_i || cpu_we_i) begin
                    if (cpu_addr_i[1:0] == 2'b00) begin
                        cpu_stall_o = 1'b1;
                        accept      = 1'b1;
                        state_d     = REQ;
                    end else begin
                        cpu_err_o = 1'b1;
                    end
                end
            end
            REQ: begin
                cpu_stall_o = 1'b1;
                // valid is withheld on the last cycle so a timeout never races a handshake
                if (last_cycle) begin
                    tmo     = 1'b1;
                    state_d = DONE;
                end else begin
                    mem_req_valid_o = 1'b1;
                    if (mem_req_ready_i) state_d = WAIT;
                end
            end
            WAIT: begin
                cpu_stall_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    rsp_take = 1'b1;
                    state_d  = DONE;
                end else if (last_cycle) begin
                    tmo     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cpu_rdata_o = rdata_q;
                cpu_err_o   = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= cpu_addr_i;
                wdata_q <= cpu_wdata_i;
                we_q    <= cpu_we_i;
                cnt_q   <= '0;
            end else if (state_q == REQ || state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (rsp_take) begin
                rdata_q <= we_q ? 32'h0 : mem_rsp_rdata_i;
                err_q   <= mem_rsp_err_i;
            end else if (tmo) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYCLES, default 255, max cycles spent in REQ+WAIT before the transaction is forcibly ended with error.
REQ-002 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-003 reset_i  input  1  reset, synchronous and active-high.
REQ-004 cpu_addr_i  input  32  byte address from core data port.
REQ-005 cpu_wdata_i  input  32  store data.
REQ-006 cpu_re_i / cpu_we_i  input  1 each  load / store request, held by core while stalled.
REQ-007 cpu_rdata_o  output  32  load data returned to core.
REQ-008 cpu_stall_o  output  1  core SHALL hold PC while high.
REQ-009 cpu_err_o  output  1  access fault (misaligned, bus error, timeout), one cycle.
REQ-010 mem_req_valid_o / mem_req_ready_i  output/input  1 each  request handshake.
REQ-011 mem_req_we_o  output  1; mem_req_addr_o  output  32; mem_req_wdata_o  output  32.
REQ-012 mem_rsp_valid_i  input  1; mem_rsp_rdata_i  input  32; mem_rsp_err_i  input  1  response channel, no backpressure.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-014 IDLE: re|we with addr[1:0]==0 -> cpu_stall_o=1 combinationally same cycle, latch addr/wdata/we, next REQ.
REQ-015 IDLE: re|we with addr[1:0]!=0 -> no bus request, cpu_err_o=1, cpu_stall_o=0, cpu_rdata_o=0, stay IDLE.
REQ-016 re and we both high SHALL be treated as store.
REQ-017 REQ: mem_req_valid_o=1 with latched addr/we/wdata stable until mem_req_ready_i; handshake cycle -> WAIT.
REQ-018 WAIT: mem_rsp_valid_i -> latch rdata (0 for stores) and err flag, next DONE; response in REQ or IDLE SHALL be ignored.
REQ-019 DONE: cpu_stall_o=0, cpu_rdata_o=latched data, cpu_err_o=latched err; next IDLE unconditionally (no re-issue of the still-asserted request).
REQ-020 cpu_stall_o SHALL be 1 in REQ and WAIT, and in IDLE per REQ-014.
REQ-021 Minimum access: 4 cycles (IDLE, REQ, WAIT, DONE), 3 stall cycles, with ready and rsp_valid both high at first opportunity.
REQ-022 Timeout counter SHALL clear on entering REQ, increment each REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> DONE with err=1, rdata=0, mem_req_valid_o dropped.
REQ-023 Outside DONE cpu_rdata_o SHALL be 0; cpu_err_o SHALL be 0 except REQ-015 and DONE with error.
REQ-024 Back-to-back accesses SHALL start in the IDLE cycle following DONE.

Reset
REQ-025 reset_i high SHALL force IDLE, counter 0, latched addr/wdata/rdata/err 0 at the next edge.
REQ-026 During/after reset: mem_req_valid_o=0, cpu_stall_o=0 unless REQ-014 holds, cpu_err_o=0, cpu_rdata_o=0.
REQ-027 Reset mid-transaction SHALL abandon it; a late mem_rsp_valid_i arriving in IDLE SHALL be ignored.

Structure
REQ-028 State enum dmem_state_t and constant DMEM_TIMEOUT_DEFAULT=255 SHALL live in cpu_pkg.
REQ-029 Single module, no sub-module; instantiated in micro_riscv between core data port and data memory.

Verification
REQ-030 Aligned load 0x100, ready=1, rsp next cycle rdata=0xCAFEF00D -> stall 3 cycles, DONE rdata=0xCAFEF00D, err=0.
REQ-031 Store 0x204 wdata=0x12345678, ready low 5 cycles -> valid/addr/wdata stable 5 cycles, we=1, stall released 1 cycle after rsp.
REQ-032 Load 0x103 -> same-cycle err=1, stall=0, mem_req_valid_o never asserted.
REQ-033 Load with no response, TIMEOUT_CYCLES=8 -> DONE after 8 REQ/WAIT cycles, err=1, rdata=0.
REQ-034 Reset in WAIT, rsp_valid=1 next cycle -> IDLE, rsp ignored, outputs 0.
REQ-035 Two consecutive loads, rsp_err_i=1 on first -> first DONE err=1, second issues in IDLE after DONE, err=0.
